// File: rtl/sa_result_collector.sv
// sa_result_collector
//   Drain side of the systolic array. Each column's skewed int32 partial sums
//   are post-processed (rounding arithmetic right shift with saturating
//   rounding add, optional ReLU), queued in a per-column FIFO, and
//   re-assembled into complete rows handed out over a valid/ready port.
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   en_down, data_down   per-column result strobe / value from the array
//   start, row_count     begin a tile of row_count rows (sampled in IDLE only)
//   cfg_shift, cfg_relu  post-processing config, latched with start
//   out_valid/out_ready  row handshake; out_data lane j = column j
//   out_last             qualifies out_valid: final row of the tile
//   busy, done           state != IDLE / one-cycle tile-complete pulse
//   overflow             sticky: some column pushed into a full FIFO

// One result lane: post-process + FIFO.
module sa_result_collector_lane #(
  parameter int L_WIDTH = 32,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [L_WIDTH-1:0] din,
  input  logic [4:0]         shift,
  input  logic               relu,
  output logic [L_WIDTH-1:0] head,
  output logic               empty,
  output logic               ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [L_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]        wptr, rptr;
  logic               full, do_push;
  logic [L_WIDTH-1:0] rnd, sum, r;
  logic signed [L_WIDTH-1:0] y;

  // Rounding add can only overflow upward (rnd >= 0); detect it as a
  // non-negative input whose sum turned negative and clamp to max.
  always_comb begin
    rnd = '0;
    if (shift != 5'd0) rnd = L_WIDTH'(1) << (shift - 5'd1);
    sum = din + rnd;
    r   = (!din[L_WIDTH-1] && sum[L_WIDTH-1]) ? {1'b0, {(L_WIDTH-1){1'b1}}} : sum;
    y   = $signed(r) >>> shift;
    if (relu && y[L_WIDTH-1]) y = '0;
  end

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A pop frees the slot in the same cycle, so full+push+pop still writes.
  assign do_push = push && (!full || pop);
  assign ovf     = push && full && !pop;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= y;
  end
endmodule

module sa_result_collector #(
  parameter int COLS    = 5,
  parameter int L_WIDTH = 32,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0]               en_down,
  input  logic [COLS-1:0][L_WIDTH-1:0]  data_down,
  input  logic                          start,
  input  logic [7:0]                    row_count,
  input  logic [4:0]                    cfg_shift,
  input  logic                          cfg_relu,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS-1:0][L_WIDTH-1:0]  out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                       state, state_nx;
  logic [7:0]                   remaining;
  logic [4:0]                   shift_q;
  logic                         relu_q;
  logic                         start_go, pop;
  logic [COLS-1:0]              lane_empty, lane_ovf;
  logic [COLS-1:0][L_WIDTH-1:0] lane_head;

  assign start_go  = (state == IDLE) && start && (row_count != 8'd0);
  assign out_valid = (state == COLLECT) && !(|lane_empty);
  assign out_last  = out_valid && (remaining == 8'd1);
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  for (genvar j = 0; j < COLS; j++) begin : g_lane
    sa_result_collector_lane #(.L_WIDTH(L_WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .flush (start_go),
      .push  ((state == COLLECT) && en_down[j]),
      .pop   (pop),
      .din   (data_down[j]),
      .shift (shift_q),
      .relu  (relu_q),
      .head  (lane_head[j]),
      .empty (lane_empty[j]),
      .ovf   (lane_ovf[j])
    );
    assign out_data[j] = out_valid ? lane_head[j] : '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (row_count != 8'd0) ? COLLECT : DONE;
      COLLECT: if (pop && out_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_go) begin
        remaining <= row_count;
        shift_q   <= cfg_shift;
        relu_q    <= cfg_relu;
        overflow  <= 1'b0;
      end else begin
        if (pop)       remaining <= remaining - 8'd1;
        if (|lane_ovf) overflow  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sa_result_collector.sv
// tb_sa_result_collector
//   Directed bench for sa_result_collector: reset, pass-through, rounding /
//   saturation / ReLU, stalled multi-row tile, FIFO overflow, empty tile,
//   and mid-tile reset. Expected values are hand-computed constants.
module tb_sa_result_collector;
  localparam int COLS = 5;
  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [COLS-1:0]         en_down = '0;
  logic [COLS-1:0][31:0]   data_down = '0;
  logic                    start = 1'b0;
  logic [7:0]              row_count = '0;
  logic [4:0]              cfg_shift = '0;
  logic                    cfg_relu = 1'b0;
  logic                    out_valid, out_last, busy, done, overflow;
  logic                    out_ready = 1'b1;
  logic [COLS-1:0][31:0]   out_data;

  int n_pass = 0;
  int n_total = 0;

  sa_result_collector #(.COLS(COLS), .L_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en_down(en_down), .data_down(data_down),
    .start(start), .row_count(row_count), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COLS-1:0][31:0] mk(input logic [31:0] a, b, c, d, e);
    logic [COLS-1:0][31:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    return v;
  endfunction

  task automatic start_tile(input logic [7:0] rc, input logic [4:0] sh, input logic rl);
    start = 1'b1; row_count = rc; cfg_shift = sh; cfg_relu = rl;
    tick();
    start = 1'b0; row_count = '0;
  endtask

  // Pushes one row with column j lagging column 0 by j cycles.
  task automatic push_row(input string tag, input logic [COLS-1:0][31:0] v);
    for (int k = 0; k < COLS; k++) begin
      en_down = '0; en_down[k] = 1'b1;
      data_down = '0; data_down[k] = v[k];
      tick();
      if (k == COLS-2) begin
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL %s_early_valid: got %0b want 0", tag, out_valid);
        else n_pass++;
      end
    end
    en_down = '0; data_down = '0;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL %s_valid: got %0b want 1", tag, out_valid);
    else n_pass++;
  endtask

  task automatic check_row(input string tag, input logic [COLS-1:0][31:0] exp);
    for (int j = 0; j < COLS; j++) begin
      n_total++;
      if (out_data[j] !== exp[j])
        $display("FAIL %s_lane%0d: got %0d want %0d", tag, j, $signed(out_data[j]), $signed(exp[j]));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_last: got %0b want 0", out_last); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0b want 0", overflow); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
  endtask

  // Single row, drains immediately, then done pulses for one cycle.
  task automatic run_single(input string tag, input logic [4:0] sh, input logic rl,
                            input logic [COLS-1:0][31:0] v, input logic [COLS-1:0][31:0] exp);
    out_ready = 1'b1;
    start_tile(8'd1, sh, rl);
    n_total++; if (busy !== 1'b1) $display("FAIL %s_busy: got %0b want 1", tag, busy); else n_pass++;
    push_row(tag, v);
    check_row(tag, exp);
    n_total++; if (out_last !== 1'b1) $display("FAIL %s_last: got %0b want 1", tag, out_last); else n_pass++;
    tick();
    n_total++; if (done !== 1'b1) $display("FAIL %s_done: got %0b want 1", tag, done); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL %s_valid_after: got %0b want 0", tag, out_valid); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_idle: got done=%0b busy=%0b want 0 0", tag, done, busy); else n_pass++;
  endtask

  task automatic test_pass_through();
    run_single("t1", 5'd0, 1'b0, mk(10, 20, 30, 40, 50), mk(10, 20, 30, 40, 50));
  endtask

  // shift=4 relu: -40->0, 40->3, 8->1, 7->0, max saturates then >>4 = 0x07FFFFFF.
  task automatic test_round_relu();
    run_single("t2", 5'd4, 1'b1, mk(-40, 40, 8, 7, 32'h7FFF_FFFF),
               mk(0, 3, 1, 0, 32'd134217727));
  endtask

  // shift=1, no relu: saturation at max, most-negative input, round half up.
  task automatic test_round_sat();
    run_single("rs", 5'd1, 1'b0, mk(32'h7FFF_FFFF, 32'h8000_0000, 3, -3, -1),
               mk(32'd1073741823, 32'hC000_0000, 2, 32'hFFFF_FFFF, 0));
  endtask

  // shift=0 still applies ReLU.
  task automatic test_shift0_relu();
    run_single("s0", 5'd0, 1'b1, mk(-5, 5, 32'h8000_0000, 32'h7FFF_FFFF, 0),
               mk(0, 5, 0, 32'h7FFF_FFFF, 0));
  endtask

  function automatic logic [COLS-1:0][31:0] row3(input int r);
    logic [COLS-1:0][31:0] v;
    for (int j = 0; j < COLS; j++) v[j] = 32'(100*(r+1) + j);
    return v;
  endfunction

  task automatic test_stall();
    out_ready = 1'b0;
    start_tile(8'd3, 5'd0, 1'b0);
    for (int k = 0; k < COLS+2; k++) begin
      en_down = '0; data_down = '0;
      for (int j = 0; j < COLS; j++) begin
        if (k-j >= 0 && k-j < 3) begin
          en_down[j] = 1'b1;
          data_down[j] = 32'(100*(k-j+1) + j);
        end
      end
      // A start mid-tile must not reload the row counter.
      if (k == 2) begin start = 1'b1; row_count = 8'd9; end
      tick();
      start = 1'b0; row_count = '0;
      if (k >= COLS-1) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== row3(0))
          $display("FAIL t3_stall_k%0d: got v=%0b %h want 1 %h", k, out_valid, out_data, row3(0));
        else n_pass++;
      end
    end
    en_down = '0; data_down = '0;
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      check_row($sformatf("t3_row%0d", r), row3(r));
      n_total++;
      if (out_valid !== 1'b1 || out_last !== (r == 2))
        $display("FAIL t3_vl%0d: got v=%0b last=%0b want 1 %0b", r, out_valid, out_last, r == 2);
      else n_pass++;
      tick();
    end
    n_total++; if (done !== 1'b1) $display("FAIL t3_done: got %0b want 1", done); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL t3_ovf: got %0b want 0", overflow); else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    start_tile(8'd8, 5'd0, 1'b0);
    for (int i = 0; i <= DEPTH; i++) begin
      en_down = 5'b00001; data_down = '0; data_down[0] = 32'(1000 + i);
      tick();
      if (i == DEPTH-1) begin
        n_total++;
        if (overflow !== 1'b0 || out_valid !== 1'b0)
          $display("FAIL t4_full: got ovf=%0b v=%0b want 0 0", overflow, out_valid);
        else n_pass++;
      end
    end
    n_total++; if (overflow !== 1'b1) $display("FAIL t4_ovf: got %0b want 1", overflow); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      en_down = 5'b11110; data_down = '0;
      for (int j = 1; j < COLS; j++) data_down[j] = 32'(2000 + i);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data[0] !== 32'(1000 + i) || out_data[1] !== 32'(2000 + i)
          || out_last !== (i == DEPTH-1))
        $display("FAIL t4_drain%0d: got v=%0b l0=%0d l1=%0d last=%0b want 1 %0d %0d %0b",
                 i, out_valid, out_data[0], out_data[1], out_last, 1000+i, 2000+i, i == DEPTH-1);
      else n_pass++;
    end
    en_down = '0; data_down = '0;
    tick();
    n_total++; if (done !== 1'b1) $display("FAIL t4_done: got %0b want 1", done); else n_pass++;
    tick();
    n_total++; if (overflow !== 1'b1 || busy !== 1'b0)
      $display("FAIL t4_sticky: got ovf=%0b busy=%0b want 1 0", overflow, busy); else n_pass++;
  endtask

  task automatic test_empty_tile();
    start_tile(8'd0, 5'd0, 1'b0);
    n_total++; if (done !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL t5_done: got done=%0b v=%0b want 1 0", done, out_valid); else n_pass++;
    en_down = '1;
    tick();
    en_down = '0;
    n_total++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL t5_idle: got done=%0b busy=%0b v=%0b want 0 0 0", done, busy, out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_tile();
    start_tile(8'd2, 5'd0, 1'b0);
    n_total++; if (overflow !== 1'b0 || busy !== 1'b1)
      $display("FAIL t6_start: got ovf=%0b busy=%0b want 0 1", overflow, busy); else n_pass++;
    en_down = 5'b00111; data_down = mk(7, 7, 7, 0, 0);
    tick(); tick();
    en_down = '0; data_down = '0;
    rst = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL t6_rst: got busy=%0b v=%0b want 0 0", busy, out_valid); else n_pass++;
    rst = 1'b0;
    run_single("t6", 5'd0, 1'b0, mk(1, 2, 3, 4, 5), mk(1, 2, 3, 4, 5));
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_round_relu();
    test_round_sat();
    test_shift0_relu();
    test_stall();
    test_overflow();
    test_empty_tile();
    test_reset_mid_tile();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
